// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: requester identity,
// the bundled request payload and word-alignment of byte addresses.
package dmem_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr, wdata;
    } dmem_req_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

    function automatic logic is_read(input logic [3:0] we);
        return (we == 4'b0000);
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Single-port synchronous data memory: one access per cycle, read data
// appears on data_in one cycle after the address is presented.
interface data_memory_if;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic [3:0]  MemWriteEnable;
    logic [31:0] data_in;

    modport cpu (
        output addr_out,
        output data_out,
        output MemWriteEnable,
        input  data_in
    );

    modport mem (
        input  addr_out,
        input  data_out,
        input  MemWriteEnable,
        output data_in
    );
endinterface

// File: rtl/starve_counter.sv
// Saturating wait counter: counts denied cycles of the low-priority requester
// and flags when it has waited long enough to be forced through.
module starve_counter #(
    parameter int LIMIT = 8,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU MEM stage (fixed priority) and the
// debug/DMA loader, with a starvation override and per-read return routing.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,

    input  logic        dbg_req,
    input  logic [3:0]  dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,

    data_memory_if.cpu  mem
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || STARVE_LIMIT >= (1 << CNT_W)) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be 1..255 and fit in CNT_W bits");
    end

    dmem_req_t cpu_r;
    dmem_req_t dbg_r;
    dmem_req_t sel_r;

    logic   force_dbg;
    logic   cpu_gnt_c;
    logic   dbg_gnt_c;
    logic   starve_inc;
    logic   starve_clr;

    logic   rd_pend_q;
    logic   rd_pend_d;
    owner_e rd_owner_q;
    owner_e rd_owner_d;

    always_comb begin
        cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        dbg_r = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
    end

    // Grants are masked during reset so nothing reaches memory in that cycle.
    always_comb begin
        cpu_gnt_c = 1'b0;
        dbg_gnt_c = 1'b0;
        if (!rst) begin
            if (force_dbg && dbg_req) begin
                dbg_gnt_c = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt_c = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt_c = 1'b1;
            end
        end
    end

    always_comb begin
        sel_r = '0;
        if (dbg_gnt_c) begin
            sel_r = dbg_r;
        end else if (cpu_gnt_c) begin
            sel_r = cpu_r;
        end
    end

    assign mem.addr_out       = align_addr(sel_r.addr);
    assign mem.data_out       = sel_r.wdata;
    assign mem.MemWriteEnable = sel_r.we;

    always_comb begin
        rd_pend_d  = (cpu_gnt_c || dbg_gnt_c) && is_read(sel_r.we);
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = dbg_gnt_c ? OWN_DBG : OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // A read in flight when reset arrives is dropped, not returned.
    assign cpu_rvalid = rd_pend_q && !rst && (rd_owner_q == OWN_CPU);
    assign dbg_rvalid = rd_pend_q && !rst && (rd_owner_q == OWN_DBG);
    assign cpu_rdata  = mem.data_in;
    assign dbg_rdata  = mem.data_in;

    assign cpu_gnt   = cpu_gnt_c;
    assign dbg_gnt   = dbg_gnt_c;
    assign cpu_stall = cpu_req && !cpu_gnt_c;

    assign starve_inc = dbg_req && !dbg_gnt_c;
    assign starve_clr = !starve_inc;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (force_dbg)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with STARVE_LIMIT=3 and a 1-cycle
// synchronous memory model preloaded with {addr[15:0], 16'hC0DE}.
module tb_dmem_arbiter;
    localparam bit CPU = 1'b0;
    localparam bit DBG = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, dbg_req;
    logic [3:0]  cpu_we, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;

    data_memory_if mif ();

    dmem_arbiter #(.STARVE_LIMIT(3), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr [4096];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= {16'(i * 4), 16'hC0DE};
        end else begin
            for (int b = 0; b < 4; b++)
                if (mif.MemWriteEnable[b]) mem_arr[mif.addr_out[13:2]][b*8 +: 8] <= mif.data_out[b*8 +: 8];
        end
        mif.data_in <= mem_arr[mif.addr_out[13:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          own;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
        bit          stall;
        int          cyc;
    } gexp_t;

    typedef struct {
        bit          own;
        logic [31:0] data;
        int          cyc;
    } rexp_t;

    gexp_t gnt_q[$];
    rexp_t rd_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic exp_gnt(input bit own, input logic [31:0] addr, input logic [3:0] we,
                           input logic [31:0] wd, input bit stall);
        gnt_q.push_back('{own: own, addr: addr, we: we, wd: wd, stall: stall, cyc: cyc});
    endtask

    task automatic exp_rd(input bit own, input logic [31:0] data);
        rd_q.push_back('{own: own, data: data, cyc: cyc + 1});
    endtask

    task automatic drive(input logic cr, input logic [3:0] cwe, input logic [31:0] ca, input logic [31:0] cwd,
                         input logic dr, input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd);
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
        dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge and pops expectations as the DUT presents them.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (rst) begin
            chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
            chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
            chk("rst_mem_we", 32'(mif.MemWriteEnable), 32'd0);
        end else begin
            if (cpu_gnt || dbg_gnt) begin
                chk("gnt_onehot", 32'(cpu_gnt && dbg_gnt), 32'd0);
                if (gnt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_gnt: got cpu_gnt=%0b dbg_gnt=%0b expected no grant (cycle %0d)",
                             cpu_gnt, dbg_gnt, cyc);
                end else begin
                    g = gnt_q.pop_front();
                    chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
                    chk("gnt_owner_dbg", 32'(dbg_gnt), 32'(g.own));
                    chk("mem_addr_out", mif.addr_out, g.addr);
                    chk("mem_we", 32'(mif.MemWriteEnable), 32'(g.we));
                    chk("mem_data_out", mif.data_out, g.wd);
                    chk("cpu_stall", 32'(cpu_stall), 32'(g.stall));
                end
            end else begin
                chk("idle_mem_we", 32'(mif.MemWriteEnable), 32'd0);
                chk("idle_mem_addr", mif.addr_out, 32'd0);
                chk("idle_stall", 32'(cpu_stall), 32'd0);
            end
            if (cpu_rvalid || dbg_rvalid) begin
                chk("rvalid_onehot", 32'(cpu_rvalid && dbg_rvalid), 32'd0);
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: got cpu_rvalid=%0b dbg_rvalid=%0b expected none (cycle %0d)",
                             cpu_rvalid, dbg_rvalid, cyc);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rd_owner_dbg", 32'(dbg_rvalid), 32'(r.own));
                    chk("rdata", r.own ? dbg_rdata : cpu_rdata, r.data);
                end
            end
        end
    end

    bit cont_win [4] = '{CPU, CPU, CPU, DBG};
    bit wd_req   [7] = '{1, 1, 0, 1, 1, 1, 1};
    bit wd_win   [7] = '{CPU, CPU, CPU, CPU, CPU, CPU, DBG};

    initial begin
        rst = 1'b1;
        idle();
        tick();
        drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // CPU read alone
        drive(1'b1, 4'h0, 32'h1006, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_gnt(CPU, 32'h1004, 4'h0, 32'h0, 1'b0);
        exp_rd(CPU, 32'h1004C0DE);
        tick();
        idle(); tick(); tick();

        // Contention with STARVE_LIMIT=3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
            if (i < 4 && cont_win[i] == DBG) begin
                exp_gnt(DBG, 32'h200, 4'h0, 32'h0, 1'b1);
                exp_rd(DBG, 32'h0200C0DE);
            end else begin
                exp_gnt(CPU, 32'h100, 4'h0, 32'h0, 1'b0);
                exp_rd(CPU, 32'h0100C0DE);
            end
            tick();
        end
        idle(); tick(); tick();

        // Interleaved reads
        drive(1'b1, 4'h0, 32'h300, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_gnt(CPU, 32'h300, 4'h0, 32'h0, 1'b0);
        exp_rd(CPU, 32'h0300C0DE);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h404, 32'h0);
        exp_gnt(DBG, 32'h404, 4'h0, 32'h0, 1'b0);
        exp_rd(DBG, 32'h0404C0DE);
        tick();
        idle(); tick(); tick();

        // DBG byte write then readback
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0100, 32'h2002, 32'h00AB0000);
        exp_gnt(DBG, 32'h2000, 4'b0100, 32'h00AB0000, 1'b0);
        tick();
        idle(); tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h2000, 32'h0);
        exp_gnt(DBG, 32'h2000, 4'h0, 32'h0, 1'b0);
        exp_rd(DBG, 32'h20ABC0DE);
        tick();
        idle(); tick(); tick();

        // Reset the cycle after a read grant; counter must restart from 0
        drive(1'b1, 4'h0, 32'h500, 32'h0, 1'b1, 4'h0, 32'h600, 32'h0);
        exp_gnt(CPU, 32'h500, 4'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
            if (cont_win[i] == DBG) begin
                exp_gnt(DBG, 32'h200, 4'h0, 32'h0, 1'b1);
                exp_rd(DBG, 32'h0200C0DE);
            end else begin
                exp_gnt(CPU, 32'h100, 4'h0, 32'h0, 1'b0);
                exp_rd(CPU, 32'h0100C0DE);
            end
            tick();
        end
        idle(); tick(); tick();

        // DBG withdraws after 2 denials, re-requests, forced only after 3 new denials
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 4'h0, 32'h100, 32'h0, wd_req[i], 4'hF, 32'h700, 32'hDEADBEEF);
            if (wd_win[i] == DBG) begin
                exp_gnt(DBG, 32'h700, 4'hF, 32'hDEADBEEF, 1'b1);
            end else begin
                exp_gnt(CPU, 32'h100, 4'h0, 32'h0, 1'b0);
                exp_rd(CPU, 32'h0100C0DE);
            end
            tick();
        end
        drive(1'b1, 4'h0, 32'h700, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_gnt(CPU, 32'h700, 4'h0, 32'h0, 1'b0);
        exp_rd(CPU, 32'hDEADBEEF);
        tick();
        idle(); tick(); tick(); tick();

        chk("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
